// File: rtl/clock_prog.sv
// clock_prog: programmable low/high waveform generator clocked by Ref_clk.
// After Latency cycles low, emits a repeating pattern of Offset low cycles
// followed by Pulse_Width high cycles. Rise_strobe marks the first high cycle.
module clock_prog #(
  parameter int unsigned Latency     = 0,
  parameter int unsigned Offset      = 1,
  parameter int unsigned Pulse_Width = 1,
  parameter int unsigned CNT_W       = 8
) (
  output logic Clock_out,
  input  logic Ref_clk,
  input  logic reset_,
  output logic Rise_strobe
);

  // Zero-length phases are promoted to one cycle so the waveform never sticks.
  localparam int unsigned OffsetEff = (Offset == 0) ? 1 : Offset;
  localparam int unsigned PulseEff  = (Pulse_Width == 0) ? 1 : Pulse_Width;

  localparam logic [CNT_W-1:0] OffLoad = CNT_W'(OffsetEff - 1);
  localparam logic [CNT_W-1:0] PwLoad  = CNT_W'(PulseEff - 1);
  localparam logic [CNT_W-1:0] LatLoad = (Latency > 0) ? CNT_W'(Latency - 1) : '0;

  typedef enum logic [1:0] {
    StWait = 2'b00,
    StLow  = 2'b01,
    StHigh = 2'b10
  } state_e;

  localparam state_e           RstState = (Latency > 0) ? StWait : StLow;
  localparam logic [CNT_W-1:0] RstCnt   = (Latency > 0) ? LatLoad : OffLoad;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_clk_out;
  logic             w_clk_out_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Next-state and next-output logic. The output flops sample the current
  // state, so Clock_out trails the state register by one edge; that places
  // the first high cycle at Latency+Offset_eff+1 counted from reset release.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt - CNT_W'(1);
    w_clk_out_nxt = 1'b0;
    w_rise_nxt    = 1'b0;

    case (r_state)
      StWait: begin
        if (w_cnt_zero) begin
          w_state_nxt = StLow;
          w_cnt_nxt   = OffLoad;
        end
      end
      StLow: begin
        if (w_cnt_zero) begin
          w_state_nxt = StHigh;
          w_cnt_nxt   = PwLoad;
        end
      end
      StHigh: begin
        w_clk_out_nxt = 1'b1;
        // The counter is only at its load value on the first HIGH cycle.
        w_rise_nxt    = (r_cnt == PwLoad);
        if (w_cnt_zero) begin
          w_state_nxt = StLow;
          w_cnt_nxt   = OffLoad;
        end
      end
      default: begin
        // Unused encoding: restart a clean low phase.
        w_state_nxt = StLow;
        w_cnt_nxt   = OffLoad;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge Ref_clk) begin
    if (!reset_) begin
      r_state   <= RstState;
      r_cnt     <= RstCnt;
      r_clk_out <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_rise    <= w_rise_nxt;
    end
  end

  assign Clock_out   = r_clk_out;
  assign Rise_strobe = r_rise;

endmodule

// File: tb/tb_clock_prog.sv
// tb_clock_prog: table vectors, hand sequences and randomised reset activity
// across several parameterisations, checked against an arithmetic model.
module tb_clock_prog;

  logic clk;
  logic rst_n;

  logic clk_a, rise_a;  // defaults
  logic clk_b, rise_b;  // L3 O2 P1
  logic clk_c, rise_c;  // L0 O3 P5
  logic clk_d, rise_d;  // O0 P0
  logic clk_e, rise_e;  // L5 O4 P3, narrow counter

  int n_cyc;
  int n_checks;
  int n_pass;

  clock_prog u_a (
    .Clock_out(clk_a), .Ref_clk(clk), .reset_(rst_n), .Rise_strobe(rise_a)
  );
  clock_prog #(.Latency(3), .Offset(2), .Pulse_Width(1), .CNT_W(8)) u_b (
    .Clock_out(clk_b), .Ref_clk(clk), .reset_(rst_n), .Rise_strobe(rise_b)
  );
  clock_prog #(.Latency(0), .Offset(3), .Pulse_Width(5), .CNT_W(8)) u_c (
    .Clock_out(clk_c), .Ref_clk(clk), .reset_(rst_n), .Rise_strobe(rise_c)
  );
  clock_prog #(.Latency(0), .Offset(0), .Pulse_Width(0), .CNT_W(8)) u_d (
    .Clock_out(clk_d), .Ref_clk(clk), .reset_(rst_n), .Rise_strobe(rise_d)
  );
  clock_prog #(.Latency(5), .Offset(4), .Pulse_Width(3), .CNT_W(4)) u_e (
    .Clock_out(clk_e), .Ref_clk(clk), .reset_(rst_n), .Rise_strobe(rise_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since the last edge that sampled reset low (0 = in reset).
  always @(posedge clk) begin
    if (!rst_n) n_cyc <= 0;
    else        n_cyc <= n_cyc + 1;
  end

  // Expected outputs in cycle n, derived from the timing rules directly.
  function automatic void model(input int n, input int l, input int o, input int p,
                                output logic c, output logic r);
    int oe, pe, per, m;
    oe = (o == 0) ? 1 : o;
    pe = (p == 0) ? 1 : p;
    per = oe + pe;
    c = 1'b0;
    r = 1'b0;
    if (n > l + oe) begin
      m = (n - l - oe - 1) % per;
      c = (m < pe);
      r = (m == 0);
    end
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b expected=%b t=%0t", name, n_cyc, act, exp, $time);
  endtask

  task automatic check_model();
    logic c, r;
    model(n_cyc, 0, 1, 1, c, r); chk("a_clk", clk_a, c); chk("a_rise", rise_a, r);
    model(n_cyc, 3, 2, 1, c, r); chk("b_clk", clk_b, c); chk("b_rise", rise_b, r);
    model(n_cyc, 0, 3, 5, c, r); chk("c_clk", clk_c, c); chk("c_rise", rise_c, r);
    model(n_cyc, 0, 0, 0, c, r); chk("d_clk", clk_d, c); chk("d_rise", rise_d, r);
    model(n_cyc, 5, 4, 3, c, r); chk("e_clk", clk_e, c); chk("e_rise", rise_e, r);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic a_clk, a_rise;
    logic b_clk, b_rise;
    logic c_clk, c_rise;
  } vec_t;

  vec_t vecs [12];

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Expected waveforms for cycles 1..12 after release.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset for two cycles.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_a_clk", clk_a, 1'b0);
      chk("rst_b_clk", clk_b, 1'b0);
      chk("rst_c_rise", rise_c, 1'b0);
    end
    rst_n = 1'b1;

    // Table-driven cycles 1..12; Offset/Pulse_Width 0 must match the defaults.
    for (int i = 0; i < 12; i++) begin
      step();
      chk("tbl_a_clk", clk_a, vecs[i].a_clk);
      chk("tbl_a_rise", rise_a, vecs[i].a_rise);
      chk("tbl_b_clk", clk_b, vecs[i].b_clk);
      chk("tbl_b_rise", rise_b, vecs[i].b_rise);
      chk("tbl_c_clk", clk_c, vecs[i].c_clk);
      chk("tbl_c_rise", rise_c, vecs[i].c_rise);
      chk("tbl_d_clk", clk_d, vecs[i].a_clk);
      chk("tbl_d_rise", rise_d, vecs[i].a_rise);
      check_model();
    end

    // u_c is high in cycles 12..16; pulse reset during its third high cycle (14).
    for (int i = 0; i < 2; i++) begin
      step();
      check_model();
    end
    chk("c_high_before_reset", clk_c, 1'b1);
    rst_n = 1'b0;
    step();
    chk("mid_high_reset_c_clk", clk_c, 1'b0);
    chk("mid_high_reset_c_rise", rise_c, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("restart_c_clk", clk_c, (i >= 4) ? 1'b1 : 1'b0);
      chk("restart_c_rise", rise_c, (i == 4) ? 1'b1 : 1'b0);
      check_model();
    end

    // Long reset: everything stays low.
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_a_clk", clk_a, 1'b0);
      chk("hold_b_rise", rise_b, 1'b0);
      chk("hold_c_clk", clk_c, 1'b0);
      chk("hold_e_clk", clk_e, 1'b0);
      chk("hold_e_rise", rise_e, 1'b0);
    end
    rst_n = 1'b1;

    // Random reset pulses of random length over a long run.
    for (int i = 0; i < 3000; i++) begin
      step();
      check_model();
      if (rst_n) rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      else       rst_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
